// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor with one borrow flop; WIDTH+1 edges start-to-done, one op in flight.
// i_start is only accepted in IDLE or DONE, so a caller holding it high gets back-to-back results.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH:0]   o_result,
  output logic             o_borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] term1_sr;
  logic [WIDTH-1:0] term2_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    count;

  logic             a;
  logic             b;
  logic             d;
  logic             borrow_next;
  logic [WIDTH-1:0] diff_next;
  logic             last_bit;

  always_comb begin
    a           = term1_sr[0];
    b           = term2_sr[0];
    d           = a ^ b ^ borrow;
    borrow_next = (~a & b) | (~(a ^ b) & borrow);
    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    diff_next   = WIDTH'({d, diff_sr} >> 1);
    last_bit    = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      term1_sr <= '0;
      term2_sr <= '0;
      diff_sr  <= '0;
      borrow   <= 1'b0;
      count    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_borrow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            term1_sr <= i_sub_term1;
            term2_sr <= i_sub_term2;
            diff_sr  <= '0;
            borrow   <= 1'b0;
            count    <= '0;
            o_busy   <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          term1_sr <= term1_sr >> 1;
          term2_sr <= term2_sr >> 1;
          diff_sr  <= diff_next;
          borrow   <= borrow_next;
          count    <= count + CW'(1);
          if (last_bit) begin
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_result <= {borrow_next, diff_next};
            o_borrow <= borrow_next;
            state    <= DONE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=2: directed scenarios, exhaustive and random pairs vs. plain arithmetic.
module tb_serial_subtractor;
  localparam int W = 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] term1;
  logic [W-1:0] term2;
  logic         busy;
  logic         done;
  logic [W:0]   result;
  logic         borrow;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_sub_term1(term1), .i_sub_term2(term2),
    .o_busy(busy), .o_done(done), .o_result(result), .o_borrow(borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model_diff(input int t1, input int t2);
    int diff;
    diff = t1 - t2;
    return diff[W:0];
  endfunction

  // Runs one operation; reports latency in edges from the start edge, busy cycles, and whether
  // o_result held its prior value while busy.
  task automatic run_op(input int t1, input int t2, output bit seen, output int lat,
                        output int busy_cnt, output bit held);
    logic [W:0] prev;
    term1 = t1[W-1:0];
    term2 = t2[W-1:0];
    tick();
    prev  = result;
    start = 1'b1;
    tick();
    start    = 1'b0;
    busy_cnt = 0;
    lat      = 1;
    held     = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if (result !== prev) held = 1'b0;
      tick();
      lat++;
    end
    seen = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; term1 = '0; term2 = '0;
    repeat (3) tick();
    checks++;
    if ({busy, done, result, borrow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%b borrow=%b, want all 0",
               busy, done, result, borrow);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit seen, held; int lat, bc;
    run_op(0, 1, seen, lat, bc, held);
    checks++;
    if (!seen || lat != W + 1) begin
      errors++; $display("FAIL t1_latency: got seen=%0d lat=%0d, want 1 and %0d", seen, lat, W + 1);
    end
    checks++;
    if (result !== 3'b111 || borrow !== 1'b1) begin
      errors++; $display("FAIL t1_result: got %b/%b, want 111/1", result, borrow);
    end
    checks++;
    if (bc != W || busy !== 1'b0) begin
      errors++; $display("FAIL t1_busy: got %0d cycles (busy now %b), want %0d and 0", bc, busy, W);
    end
    tick();
    checks++;
    if (done !== 1'b0 || result !== 3'b111) begin
      errors++; $display("FAIL t1_done_pulse: got done=%b result=%b, want 0 and 111", done, result);
    end
  endtask

  task automatic test_sequential();
    int t1s[4] = '{2, 1, 3, 3};
    int t2s[4] = '{1, 3, 3, 0};
    logic [W:0] exp_r[4] = '{3'b001, 3'b110, 3'b000, 3'b011};
    bit exp_b[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit seen, held; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(t1s[i], t2s[i], seen, lat, bc, held);
      checks++;
      if (!seen || result !== exp_r[i] || borrow !== exp_b[i]) begin
        errors++;
        $display("FAIL seq_op%0d: got seen=%0d result=%b borrow=%b, want 1 %b %b",
                 i, seen, result, borrow, exp_r[i], exp_b[i]);
      end
      checks++;
      if (!held) begin
        errors++; $display("FAIL seq_hold%0d: o_result changed during SHIFT, want held", i);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    term1 = 2'd2; term2 = 2'd1;
    tick();
    start = 1'b1;
    tick();
    term1 = 2'd0; term2 = 2'd3;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || result !== 3'b001) begin
      errors++; $display("FAIL b2b_first: got done=%b result=%b, want 1 001", done, result);
    end
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!done && gap < 10);
    checks++;
    if (gap != W + 1 || result !== 3'b101 || borrow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got gap=%0d result=%b borrow=%b, want %0d 101 1", gap, result, borrow, W + 1);
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_start_in_shift();
    int pulses = 0;
    term1 = 2'd1; term2 = 2'd2;
    tick();
    start = 1'b1;
    tick();
    term1 = 2'd3; term2 = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        pulses++;
        checks++;
        if (result !== 3'b111) begin
          errors++; $display("FAIL shift_ignore_result: got %b, want 111", result);
        end
      end
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL shift_ignore_count: got %0d done pulses, want 1", pulses);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen, held; int lat, bc; int pulses = 0;
    term1 = 2'd1; term2 = 2'd3;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, result, borrow} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b result=%b borrow=%b, want all 0",
               busy, done, result, borrow);
    end
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midreset_discard: got %0d busy/done cycles, want 0", pulses);
    end
    run_op(3, 1, seen, lat, bc, held);
    checks++;
    if (!seen || result !== 3'b010 || borrow !== 1'b0) begin
      errors++; $display("FAIL midreset_fresh: got seen=%0d result=%b borrow=%b, want 1 010 0", seen, result, borrow);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    bit seen, held; int lat, bc;
    for (int t1 = 0; t1 < 4; t1++) begin
      for (int t2 = 0; t2 < 4; t2++) begin
        run_op(t1, t2, seen, lat, bc, held);
        checks++;
        if (!seen || lat != W + 1 || result !== model_diff(t1, t2) || borrow !== (t1 < t2)) begin
          errors++;
          $display("FAIL exh_%0d_%0d: got seen=%0d lat=%0d result=%b borrow=%b, want 1 %0d %b %b",
                   t1, t2, seen, lat, result, borrow, W + 1, model_diff(t1, t2), t1 < t2);
        end
        tick();
      end
    end
  endtask

  task automatic test_random();
    bit seen, held; int lat, bc; int t1, t2;
    for (int i = 0; i < 20; i++) begin
      t1 = int'($urandom_range(0, 3));
      t2 = int'($urandom_range(0, 3));
      run_op(t1, t2, seen, lat, bc, held);
      checks++;
      if (!seen || result !== model_diff(t1, t2) || borrow !== (t1 < t2) || bc != W) begin
        errors++;
        $display("FAIL rand%0d_%0d_%0d: got seen=%0d result=%b borrow=%b busy=%0d, want 1 %b %b %0d",
                 i, t1, t2, seen, result, borrow, bc, model_diff(t1, t2), t1 < t2, W);
      end
      if (i % 3 != 0) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequential();
    test_back_to_back();
    test_start_in_shift();
    test_reset_mid_op();
    test_exhaustive();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Sequential subtractor of two WIDTH-bit unsigned operands; result is WIDTH+1-bit two's complement (i_sub_term1 - i_sub_term2).
- Bit-serial, LSB first, one bit per clock, single borrow flip-flop.
- Companion/inverse of the team's combinational nBitAdder, whose sum is WIDTH+1 bits wide.
- Used where area matters more than latency; start/busy/done handshake to a controlling block.

Parameters:
- WIDTH, 8, operand width in bits (>= 1).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_start  input  1  request; sampled only in IDLE or DONE.
- i_sub_term1  input  WIDTH  minuend, unsigned; captured on accepted start.
- i_sub_term2  input  WIDTH  subtrahend, unsigned; captured on accepted start.
- o_busy  output  1  high while state is SHIFT.
- o_done  output  1  one-cycle pulse; result valid.
- o_result  output  WIDTH+1  two's complement difference; holds until next completion.
- o_borrow  output  1  final borrow, equal to o_result[WIDTH]; 1 when term1 < term2.

Behaviour:
Reset (asynchronous, immediate, any state, mid-operation included):
- State goes to IDLE.
- o_busy=0, o_done=0, o_result=0, o_borrow=0.
- Operand shift registers, bit counter and borrow flip-flop cleared.
- An in-flight operation is discarded; no o_done is produced for it.

FSM states: IDLE, SHIFT, DONE.
- IDLE: i_start=1 -> latch both operands, borrow=0, count=0 -> SHIFT. Otherwise stay.
- SHIFT: each edge processes bit a=term1_sr[0], b=term2_sr[0]:
  - d = a ^ b ^ borrow
  - borrow_next = (~a & b) | (~(a ^ b) & borrow)
  - d is shifted into diff_sr from the MSB end; operand registers shift right; count increments.
  - On the edge with count = WIDTH-1 -> DONE, and o_result <= {borrow_next, diff_sr_next} and o_borrow <= borrow_next are loaded on that same edge.
  - i_start is ignored in SHIFT; the latched operands are unaffected by input changes.
- DONE: o_done=1 for exactly this cycle.
  - i_start=1 -> accepted as in IDLE -> SHIFT (back-to-back operation).
  - Otherwise -> IDLE.

Latency and throughput:
- Start sampled at edge k; o_busy high during cycles k+1..k+WIDTH; o_done high in the cycle after edge k+WIDTH.
- Total latency WIDTH+1 edges.
- Throughput is one result per WIDTH+1 cycles.

Arithmetic:
- The result is exact over the full range, from -(2^WIDTH-1) to 2^WIDTH-1.
- No overflow is possible.
- o_result[WIDTH] is the sign bit and the final borrow.

Boundary conditions:
- WIDTH=1 gives a single SHIFT cycle.
- Equal operands give result 0, borrow 0.
- 0 - max gives -(2^WIDTH-1).
- o_result is unchanged between completions, including while a new operation is in SHIFT.

Test Plan:
All scenarios use WIDTH=2; operands are applied one cycle before i_start.
1. term1=0, term2=1, start pulse -> o_done 3 cycles later, o_result=3'b111 (-1), o_borrow=1; o_busy high for exactly 2 cycles.
2. Sequential ops (2,1), (1,3), (3,3), (3,0) -> o_result 3'b001, 3'b110, 3'b000, 3'b011; o_borrow 0,1,0,0.
3. Hold i_start high continuously with operands (2,1), then change to (0,3) mid-SHIFT -> first result 3'b001 unaffected by the change; back-to-back accept in DONE yields second result 3'b101 (-3); o_done pulses every 3 cycles.
4. Pulse i_start during SHIFT with different operands -> ignored; only one o_done, carrying the originally latched operands.
5. Assert i_rst during the second SHIFT cycle of op (1,3) -> outputs immediately 0, state IDLE, no o_done; a fresh op (3,1) afterwards yields 3'b010.
6. Exhaustive 16 operand pairs, self-checking against term1 - term2 sign-extended to 3 bits -> all match, o_borrow == (term1 < term2).
